// File: rtl/fir_dac_tx_if.sv
// Sample stream from the FIR filter into the DAC transmitter.
// The source cannot stall: din_ready is status only, din_valid is never
// held off by it.
interface fir_dac_tx_if #(
  parameter int M = 14
) ();
  logic signed [M-1:0] din;
  logic                din_valid;
  logic                din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/fir_dac_tx.sv
// Serialises signed FIR samples into 16-bit offset-binary SPI frames for a DAC.
// A one-entry holding buffer decouples the non-stallable sample source from the
// serial link. Samples that get replaced before they are sent are counted.
// Frame timing: SETUP (1 tick), SHIFT (32 half-periods), HOLD (1 tick).
module fir_dac_tx #(
  parameter int M       = 14,
  parameter int CLK_DIV = 2
) (
  input  logic         dclk,
  input  logic         rst_n,
  fir_dac_tx_if.slave  src,
  output logic         cs_n,
  output logic         sclk,
  output logic         sdo,
  output logic         busy,
  output logic [7:0]   overrun_cnt
);

  // Gray-coded so that cs_n is a direct flop bit and every legal transition
  // flips exactly one bit; state[0] is high exactly while the DAC is selected.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    SHIFT = 2'b11,
    HOLD  = 2'b10
  } state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t              state, state_nx;
  logic [DW-1:0]       div_cnt;
  logic                tick;
  logic [4:0]          half_cnt;
  logic                sclk_q;
  logic [15:0]         shreg;
  logic [15:0]         frame;
  logic signed [M-1:0] buf_data;
  logic                buf_full;
  logic                consume;
  logic                state_change;

  assign tick         = (div_cnt == DW'(CLK_DIV - 1));
  assign state_change = (state_nx != state);

  // Offset-binary frame from the buffered sample, left-justified, zero LSBs.
  always_comb begin
    frame          = '0;
    frame[15 -: M] = {~buf_data[M-1], buf_data[M-2:0]};
  end

  // Next-state decode; the buffer is consumed on the IDLE->SETUP edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_nx = state;
    consume  = 1'b0;
    unique case (state)
      IDLE: begin
        if (buf_full) begin
          consume  = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_nx = SHIFT;
      end
      SHIFT: begin
        // 32 half-periods: 16 rising edges each followed by its falling edge.
        if (tick && half_cnt == 5'd31) state_nx = HOLD;
      end
      HOLD: begin
        if (tick) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset aborts any frame and raises cs_n at once.
  always_ff @(posedge dclk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Half-period divider, restarted on every state entry.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n)                    div_cnt <= '0;
    else if (state_change || tick) div_cnt <= '0;
    else                           div_cnt <= div_cnt + DW'(1);
  end

  // Half-periods completed inside SHIFT.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n)                       half_cnt <= '0;
    else if (state_change)            half_cnt <= '0;
    else if (state == SHIFT && tick)  half_cnt <= half_cnt + 5'd1;
  end

  // Serial clock toggles on each tick in SHIFT; 32 toggles leave it low.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n)                      sclk_q <= 1'b0;
    else if (state == SHIFT && tick) sclk_q <= ~sclk_q;
  end

  // Shift register: loaded on consume, advances on each falling sclk and
  // shifts in zeros, so it is empty (sdo low) again by HOLD/IDLE.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n)                                shreg <= '0;
    else if (consume)                          shreg <= frame;
    else if (state == SHIFT && tick && sclk_q) shreg <= {shreg[14:0], 1'b0};
  end

  // Holding buffer payload; only meaningful while buf_full is set.
  always_ff @(posedge dclk) begin
    // NOTE: the payload has no reset on purpose; buf_full gates its use, and
    // leaving data registers unreset keeps them out of the reset tree.
    if (src.din_valid) buf_data <= src.din;
  end

  // Buffer full flag: a write wins over a simultaneous consume.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n)             buf_full <= 1'b0;
    else if (src.din_valid) buf_full <= 1'b1;
    else if (consume)       buf_full <= 1'b0;
  end

  // Saturating count of samples overwritten before they were sent.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n)
      overrun_cnt <= '0;
    else if (src.din_valid && buf_full && !consume && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end

  assign src.din_ready = ~buf_full;
  assign cs_n          = ~state[0];
  assign sclk          = sclk_q;
  assign sdo           = shreg[15];
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_fir_dac_tx.sv
// Bench for fir_dac_tx: spec-constant vector table, hand sequences for the
// buffering/reset corner cases, and scheduled random traffic compared with a
// transaction-level model of the buffer and link occupancy.
module tb_fir_dac_tx;
  localparam int M    = 14;
  localparam int CD   = 2;
  localparam int FLEN = 34 * CD;

  logic       dclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n, sclk, sdo, busy;
  logic [7:0] overrun_cnt;

  always #5 dclk = ~dclk;

  fir_dac_tx_if #(.M(M)) bus ();

  fir_dac_tx #(.M(M), .CLK_DIV(CD)) dut (
    .dclk        (dclk),
    .rst_n       (rst_n),
    .src         (bus),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .sdo         (sdo),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- DAC-side monitor (samples on falling dclk) -------------
  typedef struct {
    logic [15:0] frame;
    int          bits;
    int          cs_len;
  } cap_t;

  cap_t        cap_q[$];
  int          busy_q[$];
  int          gap_q[$];
  logic [15:0] cap;
  int          nbits, cs_len, busy_len, gap_len;
  logic        p_sclk, p_cs, p_busy, p_sdo;
  int          sdo_age, rise_age;
  int          stab_err = 0;

  always @(negedge dclk) begin
    if (!rst_n) begin
      cap = '0; nbits = 0; cs_len = 0; busy_len = 0; gap_len = 0;
      p_sclk = 1'b0; p_cs = 1'b1; p_busy = 1'b0; p_sdo = 1'b0;
      sdo_age = 100; rise_age = 100;
    end else begin
      sdo_age  = (sdo !== p_sdo) ? 0 : sdo_age + 1;
      rise_age = rise_age + 1;
      if (!cs_n && sclk && !p_sclk) begin
        if (sdo_age < CD) stab_err++;
        rise_age = 0;
        cap      = {cap[14:0], sdo};
        nbits++;
      end
      if (sdo !== p_sdo && rise_age < CD) stab_err++;
      if (cs_n && !p_cs) begin
        cap_q.push_back('{cap, nbits, cs_len});
        cap = '0; nbits = 0; cs_len = 0;
      end
      if (!busy && p_busy) begin busy_q.push_back(busy_len); busy_len = 0; end
      if (busy && !p_busy) begin gap_q.push_back(gap_len);   gap_len  = 0; end
      if (!cs_n) cs_len++;
      if (busy) busy_len++; else gap_len++;
      p_sclk = sclk; p_cs = cs_n; p_busy = busy; p_sdo = sdo;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  task automatic send(input int d);
    bus.din       = M'(d);
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
  endtask

  // Offset binary: add half range, wrap to M bits, left-justify in 16.
  function automatic logic [15:0] ref_frame(input int d);
    return 16'(((d + 2 ** (M - 1)) % (2 ** M)) * (2 ** (16 - M)));
  endfunction

  task automatic drain(input string tag);
    int quiet = 0;
    bit ok    = 1'b0;
    for (int i = 0; i < 6 * FLEN; i++) begin
      step();
      if (!busy && bus.din_ready) quiet++; else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
    check({tag, " drain"}, 32'(ok), 32'd1);
  endtask

  // ---------------- schedule + transaction-level model ----------------
  bit sch_v[];
  int sch_d[];
  int exp_ovr = 0;

  task automatic run_sched(input string tag);
    logic [15:0] exp_q[$];
    bit full    = 1'b0;
    int bufd    = 0;
    int free_at = 0;
    for (int k = 0; k < sch_v.size(); k++) begin
      bit cons = full && (k >= free_at);
      if (cons) begin
        exp_q.push_back(ref_frame(bufd));
        full    = 1'b0;
        free_at = k + FLEN + 1;
      end
      if (sch_v[k]) begin
        if (full) exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
        bufd = sch_d[k];
        full = 1'b1;
      end
    end
    if (full) exp_q.push_back(ref_frame(bufd));

    cap_q.delete();
    for (int k = 0; k < sch_v.size(); k++) begin
      bus.din_valid = sch_v[k];
      bus.din       = M'(sch_d[k]);
      step();
    end
    bus.din_valid = 1'b0;
    drain(tag);
    check({tag, " frame count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check($sformatf("%s frame%0d", tag, i), 32'(cap_q[i].frame), 32'(exp_q[i]));
      check($sformatf("%s bits%0d", tag, i), 32'(cap_q[i].bits), 32'd16);
    end
    check({tag, " overrun_cnt"}, 32'(overrun_cnt), 32'(exp_ovr));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          din;
    logic [15:0] frame;
    int          cs_len;
    int          busy_len;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0,     16'h8000, 66, 68};
    vt[1] = '{8191,  16'hFFFC, 66, 68};
    vt[2] = '{-8192, 16'h0000, 66, 68};
    vt[3] = '{-1,    16'h7FFC, 66, 68};
    vt[4] = '{1,     16'h8004, 66, 68};
    vt[5] = '{-4096, 16'h4000, 66, 68};

    bus.din       = '0;
    bus.din_valid = 1'b0;

    // Reset values while held and just after release.
    repeat (3) step();
    check("rst cs_n",        32'(cs_n),          32'd1);
    check("rst sclk",        32'(sclk),          32'd0);
    check("rst sdo",         32'(sdo),           32'd0);
    check("rst busy",        32'(busy),          32'd0);
    check("rst din_ready",   32'(bus.din_ready), 32'd1);
    check("rst overrun_cnt", 32'(overrun_cnt),   32'd0);
    rst_n = 1'b1;
    repeat (4) step();
    check("post-rst idle cs_n", 32'(cs_n), 32'd1);

    // Single-sample frames: latency, content, cs_n and busy lengths.
    for (int i = 0; i < 6; i++) begin
      cap_q.delete();
      busy_q.delete();
      send(vt[i].din);
      check($sformatf("v%0d cs_n before", i),      32'(cs_n),          32'd1);
      check($sformatf("v%0d ready buffered", i),   32'(bus.din_ready), 32'd0);
      step();
      check($sformatf("v%0d cs_n latency", i),     32'(cs_n),          32'd0);
      check($sformatf("v%0d ready consumed", i),   32'(bus.din_ready), 32'd1);
      check($sformatf("v%0d busy", i),             32'(busy),          32'd1);
      drain($sformatf("v%0d", i));
      check($sformatf("v%0d frame count", i), 32'(cap_q.size()), 32'd1);
      if (cap_q.size() > 0) begin
        check($sformatf("v%0d frame", i),   32'(cap_q[0].frame),  32'(vt[i].frame));
        check($sformatf("v%0d bits", i),    32'(cap_q[0].bits),   32'd16);
        check($sformatf("v%0d cs_len", i),  32'(cap_q[0].cs_len), 32'(vt[i].cs_len));
      end
      if (busy_q.size() > 0)
        check($sformatf("v%0d busy_len", i), 32'(busy_q[0]), 32'(vt[i].busy_len));
      else
        check($sformatf("v%0d busy seen", i), 32'(busy_q.size()), 32'd1);
    end

    // Valid on the exact IDLE->SETUP edge: old sent, new buffered, no overrun.
    cap_q.delete();
    gap_q.delete();
    send(100);
    send(-200);
    check("edge ready", 32'(bus.din_ready), 32'd0);
    check("edge cs_n",  32'(cs_n),          32'd0);
    drain("edge");
    check("edge frame count", 32'(cap_q.size()), 32'd2);
    if (cap_q.size() == 2) begin
      check("edge frame0", 32'(cap_q[0].frame), 32'(ref_frame(100)));
      check("edge frame1", 32'(cap_q[1].frame), 32'(ref_frame(-200)));
    end
    check("edge gap count", 32'(gap_q.size()), 32'd2);
    if (gap_q.size() == 2) check("edge idle gap", 32'(gap_q[1]), 32'd1);
    check("edge overrun_cnt", 32'(overrun_cnt), 32'(exp_ovr));

    // Valid every 20 cycles.
    sch_v = new[240];
    sch_d = new[240];
    for (int k = 0; k < 240; k++) begin
      sch_v[k] = (k % 20 == 0);
      sch_d[k] = int'($urandom_range(0, 2 ** M - 1)) - 2 ** (M - 1);
    end
    run_sched("every20");

    // Random sparse traffic.
    sch_v = new[900];
    sch_d = new[900];
    for (int k = 0; k < 900; k++) begin
      sch_v[k] = ($urandom_range(0, 23) == 0);
      sch_d[k] = int'($urandom_range(0, 2 ** M - 1)) - 2 ** (M - 1);
    end
    run_sched("random");

    // Continuous valid: more than 300 overwrites, counter saturates.
    sch_v = new[340];
    sch_d = new[340];
    for (int k = 0; k < 340; k++) begin
      sch_v[k] = 1'b1;
      sch_d[k] = int'($urandom_range(0, 2 ** M - 1)) - 2 ** (M - 1);
    end
    run_sched("saturate");
    check("saturate at 255", 32'(overrun_cnt), 32'd255);

    // Reset at the 8th rising sclk with a second sample buffered.
    begin
      int   rises = 0;
      logic ps    = 1'b0;
      bit   seen  = 1'b0;
      send(1234);
      send(-77);
      for (int i = 0; i < 200 && rises < 8; i++) begin
        step();
        if (sclk && !ps) rises++;
        ps = sclk;
      end
      check("mid reset reached 8th rise", 32'(rises), 32'd8);
      rst_n = 1'b0;
      #1;
      check("mid reset cs_n",        32'(cs_n),          32'd1);
      check("mid reset sclk",        32'(sclk),          32'd0);
      check("mid reset sdo",         32'(sdo),           32'd0);
      check("mid reset busy",        32'(busy),          32'd0);
      check("mid reset din_ready",   32'(bus.din_ready), 32'd1);
      check("mid reset overrun_cnt", 32'(overrun_cnt),   32'd0);
      exp_ovr = 0;
      repeat (3) step();
      rst_n = 1'b1;
      cap_q.delete();
      for (int i = 0; i < 200; i++) begin
        step();
        if (busy || !cs_n) seen = 1'b1;
      end
      check("post reset no frame",    32'(cap_q.size()), 32'd0);
      check("post reset stayed idle", 32'(seen),         32'd0);
      send(-5000);
      drain("post reset");
      check("post reset frame count", 32'(cap_q.size()), 32'd1);
      if (cap_q.size() > 0)
        check("post reset frame", 32'(cap_q[0].frame), 32'(ref_frame(-5000)));
    end

    check("sdo stability", 32'(stab_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_dac_tx.md
FIR_DAC_TX -- requirements
Module: fir_dac_tx

Interface
REQ-001 SHALL have parameter M, default 14, meaning width of the signed filter sample; legal range 2..16.
REQ-002 SHALL have parameter CLK_DIV, default 2, meaning dclk cycles per sclk half-period; legal range >=1.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 dclk  input  1  system/sample clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 din  input  M  signed two's-complement filter output sample.
REQ-007 din_valid  input  1  din is a new sample this cycle; the source cannot stall.
REQ-008 din_ready  output  1  high when the holding buffer is empty.
REQ-009 cs_n  output  1  DAC chip select, active-low.
REQ-010 sclk  output  1  DAC serial clock; DAC samples sdo on rising sclk.
REQ-011 sdo  output  1  DAC serial data, MSB first.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 overrun_cnt  output  8  count of samples overwritten before transmission, saturating at 255.

Function
REQ-014 SHALL hold a one-entry buffer (data, full flag); din_valid writes din into the buffer and sets full.
REQ-015 If din_valid arrives while full and the buffer is not being consumed, the new sample SHALL overwrite the buffer and overrun_cnt SHALL increment (saturating).
REQ-016 If din_valid coincides with the FSM consuming the buffer, the new sample SHALL be written, full SHALL stay 1, and no overrun SHALL be counted.
REQ-017 Frame SHALL be 16 bits: bits[15:16-M] = {~din[M-1], din[M-2:0]} (offset binary), remaining LSBs 0.
REQ-018 A half-period tick SHALL occur every CLK_DIV dclk cycles; the divider SHALL be cleared on each state entry.
REQ-019 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD.
REQ-020 IDLE: cs_n=1, sclk=0, sdo=0; if full, SHALL move to SETUP, load the shift register from the buffer, and clear full in the same edge.
REQ-021 SETUP: cs_n=0, sclk=0, sdo=frame[15]; after one tick SHALL move to SHIFT.
REQ-022 SHIFT: sclk SHALL toggle on each tick; on each falling sclk sdo SHALL advance to the next bit; after the 16th rising edge and its following falling edge, SHALL move to HOLD.
REQ-023 HOLD: cs_n=1, sclk=0; after one tick SHALL move to IDLE.
REQ-024 Frame length SHALL be 34*CLK_DIV dclk cycles from entering SETUP to re-entering IDLE.
REQ-025 Latency SHALL be: din_valid sampled at edge N causes cs_n to fall at edge N+1 if IDLE and empty.
REQ-026 A buffered sample SHALL start at the edge after HOLD exits, giving back-to-back frames with one IDLE cycle.
REQ-027 sdo SHALL be stable for CLK_DIV cycles before and after every rising sclk.

Reset
REQ-028 While rst_n=0: cs_n=1, sclk=0, sdo=0, busy=0, din_ready=1, overrun_cnt=0, state IDLE, buffer empty.
REQ-029 Reset asserted mid-frame SHALL abort immediately (cs_n high asynchronously) and discard the buffer; the partial frame is not resent.
REQ-030 After rst_n deasserts, the first transmission SHALL need a new din_valid.

Verification
REQ-031 M=14, CLK_DIV=2, din=0 single valid -> cs_n low for 66 cycles, sdo bits 0x8000, busy 68 cycles.
REQ-032 din=8191, then din=-8192 after the first frame -> frames 0xFFFC then 0x0000; din=-1 -> 0x7FFC.
REQ-033 Valid pulses every 20 cycles with CLK_DIV=2 -> first sample sent, one buffered, the rest overwrite; overrun_cnt counts every overwrite; the sample sent next is the last written.
REQ-034 din_valid on the exact IDLE->SETUP edge with full=1 -> old sample transmitted, new one buffered, overrun_cnt unchanged.
REQ-035 rst_n pulsed low at the 8th rising sclk -> cs_n=1 immediately, all outputs at reset values, no frame until the next din_valid.
REQ-036 300 forced overwrites -> overrun_cnt saturates at 255.
